// File: rtl/rom_fuse_pkg.sv
// Shared types and defaults for the ROM fuse controller.
// Holds the controller FSM state encoding and the default parameter values
// (ROM address width, seal key, seal timeout) used by the interface and the top.
package rom_fuse_pkg;

  localparam int unsigned AddrWDefault       = 12;
  localparam logic [31:0] LockKeyDefault     = 32'hDEADDEAD;
  localparam int unsigned LockTimeoutDefault = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StResp,
    StKey,
    StWaitLock,
    StSealed,
    StFault
  } state_e;

endpackage

// File: rtl/rom_fuse_ctrl_if.sv
// Bus bundle between the two ROM requesters, the ROM read port and the fuse.
//   req_valid/req_addr0/req_addr1 : read requests, held until granted
//   gnt/rsp_valid/rsp_data/rsp_err: one-hot grant, one-hot response, data, deny flag
//   rom_en/rom_addr/rom_data      : ROM read port (data one cycle after rom_en)
//   lock_req/reg0/locked          : seal request, key write to fuse REG0, fuse status
//   lock_done/lock_fault          : sticky seal-success / seal-timeout flags
// slave is the controller side, master is the requester/ROM/fuse side.
interface rom_fuse_ctrl_if
  import rom_fuse_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
);
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        gnt;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              lock_req;
  logic [31:0]       reg0;
  logic              locked;
  logic              lock_done;
  logic              lock_fault;

  modport slave (
    input  req_valid, req_addr0, req_addr1, rom_data, lock_req, locked,
    output gnt, rsp_valid, rsp_data, rsp_err, rom_en, rom_addr, reg0, lock_done, lock_fault
  );

  modport master (
    output req_valid, req_addr0, req_addr1, rom_data, lock_req, locked,
    input  gnt, rsp_valid, rsp_data, rsp_err, rom_en, rom_addr, reg0, lock_done, lock_fault
  );
endinterface

// File: rtl/rom_fuse_rr_arb.sv
// Two-way round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : request vector
//   update_i     : the grant is being taken this cycle; advance the pointer
//   gnt_o        : one-hot grant (combinational), zero when no request
// On a tie the requester not served last wins; the pointer resets to 1 so
// requester 0 wins the first tie.
module rom_fuse_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;

  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
    last_d = last_q;
    if (update_i && (req_i != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/rom_fuse_ctrl.sv
// ROM fuse controller: arbitrates two requesters onto a ROM read port until boot
// completes, then seals the fuse by writing LOCK_KEY to REG0 and waiting for
// LOCKED. Once sealed (or timed out) every request is answered with an error.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rom_fuse_ctrl_if.slave (requests, responses, ROM port, fuse)
// All outputs are registered except rsp_data, which forwards ROM data during
// the response cycle because the ROM returns it one cycle after rom_en.
module rom_fuse_ctrl
  import rom_fuse_pkg::*;
#(
  parameter int unsigned ADDR_W       = AddrWDefault,
  parameter logic [31:0] LOCK_KEY     = LockKeyDefault,
  parameter int unsigned LOCK_TIMEOUT = LockTimeoutDefault
) (
  input logic            clk,
  input logic            rst,
  rom_fuse_ctrl_if.slave bus
);
  localparam int unsigned CntW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        sel_q, sel_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]       reg0_q, reg0_d;
  logic              lock_done_q, lock_done_d;
  logic              lock_fault_q, lock_fault_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        arb_gnt;
  logic              arb_update;

  rom_fuse_rr_arb u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (bus.req_valid),
    .update_i (arb_update),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_err_d    = 1'b0;
    rom_en_d     = 1'b0;
    rom_addr_d   = '0;
    reg0_d       = 32'h0;
    sel_d        = sel_q;
    lock_done_d  = lock_done_q;
    lock_fault_d = lock_fault_q;
    cnt_d        = cnt_q;
    arb_update   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.locked) begin
          state_d     = StSealed;
          lock_done_d = 1'b1;
        end else if (bus.lock_req) begin
          state_d = StKey;
          reg0_d  = LOCK_KEY;
        end else if (bus.req_valid != 2'b00) begin
          state_d    = StRead;
          arb_update = 1'b1;
          gnt_d      = arb_gnt;
          sel_d      = arb_gnt;
          rom_en_d   = 1'b1;
          rom_addr_d = arb_gnt[1] ? bus.req_addr1 : bus.req_addr0;
        end
      end
      StRead: begin
        state_d     = StResp;
        rsp_valid_d = sel_q;
      end
      StResp: state_d = StIdle;
      StKey: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
      StWaitLock: begin
        if (bus.locked) begin
          state_d     = StSealed;
          lock_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntLast) begin
            state_d      = StFault;
            lock_fault_d = 1'b1;
          end
        end
      end
      StSealed, StFault: begin
        // Skip the cycle right after a grant: the served requester still shows
        // its consumed request until it sees the grant pulse.
        if ((gnt_q == 2'b00) && (bus.req_valid != 2'b00)) begin
          arb_update  = 1'b1;
          gnt_d       = arb_gnt;
          rsp_valid_d = arb_gnt;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= 2'b00;
      rsp_valid_q  <= 2'b00;
      sel_q        <= 2'b00;
      rsp_err_q    <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      reg0_q       <= 32'h0;
      lock_done_q  <= 1'b0;
      lock_fault_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      sel_q        <= sel_d;
      rsp_err_q    <= rsp_err_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      reg0_q       <= reg0_d;
      lock_done_q  <= lock_done_d;
      lock_fault_q <= lock_fault_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = ((rsp_valid_q != 2'b00) && !rsp_err_q) ? bus.rom_data : 32'h0;
  assign bus.rom_en     = rom_en_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.reg0       = reg0_q;
  assign bus.lock_done  = lock_done_q;
  assign bus.lock_fault = lock_fault_q;
endmodule

// File: tb/tb_rom_fuse_ctrl.sv
// Self-checking bench for rom_fuse_ctrl: directed boot/seal/fault/reset steps
// plus randomized two-requester traffic scored against a transaction model.
module tb_rom_fuse_ctrl;
  import rom_fuse_pkg::*;

  localparam int unsigned AW  = 12;
  localparam logic [31:0] KEY = 32'hDEADDEAD;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_fuse_ctrl_if #(.ADDR_W(AW)) bus ();

  rom_fuse_ctrl #(
    .ADDR_W       (AW),
    .LOCK_KEY     (KEY),
    .LOCK_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: data one cycle after rom_en, junk otherwise.
  logic [31:0] mem [4096];
  always @(posedge clk) bus.rom_data <= bus.rom_en ? mem[bus.rom_addr] : $urandom();

  // Fuse model: latches LOCKED after seeing the key (auto mode) or on force.
  logic fuse_q = 1'b0;
  logic fuse_auto = 1'b1, fuse_force = 1'b0, fuse_clear = 1'b1;
  always @(posedge clk) begin
    if (fuse_clear) fuse_q <= 1'b0;
    else if (fuse_force || (fuse_auto && bus.reg0 == KEY)) fuse_q <= 1'b1;
  end
  assign bus.locked = fuse_q;

  int n_cmp = 0;
  int n_bad = 0;
  bit mdl_last = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit clr_fuse);
    rst = 1'b1;
    fuse_clear = clr_fuse;
    bus.lock_req = 1'b0;
    bus.req_valid = 2'b00;
    step();
    step();
    rst = 1'b0;
    fuse_clear = 1'b0;
    mdl_last = 1'b1;
  endtask

  // Random requesters; the model predicts grant legality, tie order, ROM
  // address, and the response (ROM data next cycle, or same-cycle denial).
  task automatic run_random(input int ncyc, input bit sealed);
    bit pend [2];
    logic [AW-1:0] pa [2];
    int lat [2];
    logic [1:0] nxt_v, cur_v, g, rv;
    logic [31:0] nxt_d, cur_d;
    int gi;
    pend[0] = 0; pend[1] = 0; pa[0] = '0; pa[1] = '0; lat[0] = 0; lat[1] = 0;
    nxt_v = 2'b00; nxt_d = 32'h0;
    for (int c = 0; c < ncyc + 24; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && c < ncyc && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = AW'($urandom_range(0, 4095));
          lat[i]  = 0;
        end
      end
      bus.req_valid = {pend[1], pend[0]};
      bus.req_addr0 = pa[0];
      bus.req_addr1 = pa[1];
      rv = bus.req_valid;
      step();
      cur_v = nxt_v; cur_d = nxt_d; nxt_v = 2'b00;
      g = bus.gnt;
      if (g != 2'b00) begin
        gi = g[1] ? 1 : 0;
        check("gnt_onehot", $countones(g), 1);
        check("gnt_to_idle_req", g & ~rv, 0);
        if (rv == 2'b11) check("rr_tie", g, mdl_last ? 2'b01 : 2'b10);
        check("latency_bound", lat[gi] <= 8, 1);
        if (sealed) begin
          check("deny_rsp_valid", bus.rsp_valid, g);
          check("deny_rsp_err", bus.rsp_err, 1);
          check("deny_rsp_data", bus.rsp_data, 0);
        end else begin
          check("rom_en_on_gnt", bus.rom_en, 1);
          check("rom_addr", bus.rom_addr, pa[gi]);
          nxt_v = g;
          nxt_d = mem[pa[gi]];
        end
        mdl_last = g[1];
        pend[gi] = 1'b0;
      end else if (sealed) begin
        check("deny_idle_rsp", bus.rsp_valid, 0);
      end
      if (sealed) begin
        check("deny_rom_en", bus.rom_en, 0);
      end else begin
        check("rsp_valid", bus.rsp_valid, cur_v);
        check("rsp_data", bus.rsp_data, (cur_v != 2'b00) ? cur_d : 32'h0);
        if (cur_v != 2'b00) check("rsp_err", bus.rsp_err, 0);
        if (g == 2'b00) check("rom_en_idle", bus.rom_en, 0);
      end
      for (int i = 0; i < 2; i++) if (pend[i]) lat[i]++;
    end
    check("drain", {pend[1], pend[0]}, 0);
    bus.req_valid = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [1:0] exp_g [4];
    logic [AW-1:0] a0, a1;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom();
    mem[12'h010] = 32'h12345678;
    bus.req_valid = 2'b00;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;
    bus.lock_req  = 1'b0;

    // Reset state
    do_reset(1'b1);
    check("rst_flags", {bus.gnt, bus.rsp_valid, bus.rsp_err, bus.rom_en, bus.lock_done,
                        bus.lock_fault}, 0);
    check("rst_reg0", bus.reg0, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_rsp_data", bus.rsp_data, 0);

    // Single read, 2-cycle latency
    bus.req_valid = 2'b01;
    bus.req_addr0 = AW'(12'h010);
    step();
    check("rd_gnt", bus.gnt, 2'b01);
    check("rd_rom_en", bus.rom_en, 1);
    check("rd_rom_addr", bus.rom_addr, 12'h010);
    check("rd_rsp_early", bus.rsp_valid, 0);
    bus.req_valid = 2'b00;
    step();
    check("rd_rsp_valid", bus.rsp_valid, 2'b01);
    check("rd_rsp_data", bus.rsp_data, 32'h12345678);
    check("rd_rsp_err", bus.rsp_err, 0);
    check("rd_gnt_gone", bus.gnt, 0);
    step();
    check("rd_rsp_done", {bus.rsp_valid, bus.rsp_data}, 0);

    // Both requesters always valid: alternating grants
    do_reset(1'b1);
    a0 = AW'($urandom_range(0, 4095));
    a1 = AW'($urandom_range(0, 4095));
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    bus.req_addr0 = a0;
    bus.req_addr1 = a1;
    bus.req_valid = 2'b11;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.gnt != 2'b00 && k < 4) begin
        check("alt_gnt", bus.gnt, exp_g[k]);
        check("alt_addr", bus.rom_addr, exp_g[k][1] ? a1 : a0);
        k++;
      end
    end
    check("alt_count", k, 4);
    bus.req_valid = 2'b00;
    step();
    step();

    // Random unsealed traffic
    do_reset(1'b1);
    run_random(300, 1'b0);

    // In-flight read dropped by reset
    do_reset(1'b1);
    bus.req_valid = 2'b01;
    bus.req_addr0 = AW'(12'h005);
    step();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    step();
    check("drop_rsp_valid", bus.rsp_valid, 0);
    rst = 1'b0;
    step();
    check("drop_rsp_after", {bus.rsp_valid, bus.rsp_data}, 0);

    // Seal with working fuse, then denied reads
    do_reset(1'b1);
    fuse_auto = 1'b1;
    bus.lock_req = 1'b1;
    step();
    check("seal_key", bus.reg0, KEY);
    step();
    check("seal_key_once", bus.reg0, 0);
    check("seal_not_done_yet", bus.lock_done, 0);
    step();
    check("seal_done", bus.lock_done, 1);
    check("seal_no_fault", bus.lock_fault, 0);
    bus.lock_req = 1'b0;
    bus.req_valid = 2'b10;
    bus.req_addr1 = AW'(12'h123);
    step();
    check("seal_gnt", bus.gnt, 2'b10);
    check("seal_rsp", bus.rsp_valid, 2'b10);
    check("seal_err", bus.rsp_err, 1);
    check("seal_data", bus.rsp_data, 0);
    check("seal_rom_en", bus.rom_en, 0);
    bus.req_valid = 2'b00;
    mdl_last = 1'b1;
    step();
    run_random(150, 1'b0 == 1'b0 ? 1'b1 : 1'b1);
    check("seal_done_sticky", bus.lock_done, 1);

    // Seal timeout with dead fuse
    do_reset(1'b1);
    fuse_auto = 1'b0;
    bus.lock_req = 1'b1;
    step();
    check("tmo_key", bus.reg0, KEY);
    for (int j = 1; j <= 16; j++) begin
      step();
      check("tmo_fault", bus.lock_fault, (j == 16) ? 1 : 0);
    end
    check("tmo_reg0", bus.reg0, 0);
    check("tmo_no_done", bus.lock_done, 0);
    bus.lock_req = 1'b0;
    run_random(100, 1'b1);

    // Lock request beats a simultaneous read
    do_reset(1'b1);
    fuse_auto = 1'b1;
    bus.lock_req = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_addr0 = AW'(12'h010);
    step();
    check("lvr_key", bus.reg0, KEY);
    check("lvr_no_gnt", bus.gnt, 0);
    k = 0;
    while (bus.gnt == 2'b00 && k < 8) begin
      check("lvr_no_rom_en", bus.rom_en, 0);
      step();
      k++;
    end
    check("lvr_gnt", bus.gnt, 2'b01);
    check("lvr_err", bus.rsp_err, 1);
    check("lvr_data", bus.rsp_data, 0);
    check("lvr_done", bus.lock_done, 1);
    bus.req_valid = 2'b00;
    bus.lock_req = 1'b0;

    // Reset during WAIT_LOCK, fuse then reports locked
    do_reset(1'b1);
    fuse_auto = 1'b0;
    bus.lock_req = 1'b1;
    step();
    check("rwl_key", bus.reg0, KEY);
    repeat (4) step();
    check("rwl_waiting", {bus.lock_done, bus.lock_fault}, 0);
    rst = 1'b1;
    fuse_force = 1'b1;
    step();
    check("rwl_reg0", bus.reg0, 0);
    check("rwl_flags", {bus.lock_done, bus.lock_fault}, 0);
    rst = 1'b0;
    fuse_force = 1'b0;
    bus.lock_req = 1'b0;
    step();
    check("rwl_sealed", bus.lock_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
